// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned RW_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDWAIT
    } state_t;

    localparam logic [RW_W-1:0] RW_READ = 4'b0000;

    typedef logic port_idx_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way picker: round-robin on last_grant, or port 0 first when fixed_prio is set.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_idx_t  last_grant,
    input  logic       fixed_prio,
    output logic       gnt_valid,
    output port_idx_t  gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        if (req == 2'b11) begin
            gnt_idx = fixed_prio ? 1'b0 : ~last_grant;
        end else begin
            gnt_idx = req[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage (port 0) and DMA/debug (port 1).
// Optional grant/conflict counters are built when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [RW_W-1:0]   m0_rw,
    output logic              m0_done,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [RW_W-1:0]   m1_rw,
    output logic              m1_done,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              cpu_stall,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [RW_W-1:0]   mem_rw,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_gnt0,
    output logic [31:0]       perf_gnt1,
    output logic [31:0]       perf_conflict
`endif
);

    state_t            state, state_nx;
    port_idx_t         last_grant, last_grant_nx;
    port_idx_t         lat_idx, lat_idx_nx;
    port_idx_t         gnt_idx;
    logic              gnt_valid;
    logic              grant;
    logic [1:0]        req_masked;
    logic              mem_en_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic [RW_W-1:0]   mem_rw_nx;
    logic              m0_done_nx, m1_done_nx;
    logic [DATA_W-1:0] m0_rdata_nx, m1_rdata_nx;

    // Requests still held during the done cycle belong to the finished access.
    assign req_masked = {m1_req, m0_req} & {2{~(m0_done | m1_done)}};
    assign grant      = (state == IDLE) && gnt_valid;
    assign cpu_stall  = m0_req & ~m0_done;

    rr_arb2 u_rr_arb2 (
        .req        (req_masked),
        .last_grant (last_grant),
        .fixed_prio (FIXED_PRIO),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        lat_idx_nx    = lat_idx;
        mem_en_nx     = 1'b0;
        mem_addr_nx   = mem_addr;
        mem_wdata_nx  = mem_wdata;
        mem_rw_nx     = RW_READ;
        m0_done_nx    = 1'b0;
        m1_done_nx    = 1'b0;
        m0_rdata_nx   = m0_rdata;
        m1_rdata_nx   = m1_rdata;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nx      = ACCESS;
                    last_grant_nx = gnt_idx;
                    lat_idx_nx    = gnt_idx;
                    mem_en_nx     = 1'b1;
                    mem_addr_nx   = gnt_idx ? m1_addr  : m0_addr;
                    mem_wdata_nx  = gnt_idx ? m1_wdata : m0_wdata;
                    mem_rw_nx     = gnt_idx ? m1_rw    : m0_rw;
                end
            end
            ACCESS: begin
                if (mem_rw != RW_READ) begin
                    state_nx   = IDLE;
                    m0_done_nx = ~lat_idx;
                    m1_done_nx = lat_idx;
                end else begin
                    state_nx = RDWAIT;
                end
            end
            RDWAIT: begin
                state_nx = IDLE;
                if (lat_idx) begin
                    m1_done_nx  = 1'b1;
                    m1_rdata_nx = mem_rdata;
                end else begin
                    m0_done_nx  = 1'b1;
                    m0_rdata_nx = mem_rdata;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
            lat_idx    <= 1'b0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rw     <= RW_READ;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            last_grant <= last_grant_nx;
            lat_idx    <= lat_idx_nx;
            mem_en     <= mem_en_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            mem_rw     <= mem_rw_nx;
            m0_done    <= m0_done_nx;
            m1_done    <= m1_done_nx;
            m0_rdata   <= m0_rdata_nx;
            m1_rdata   <= m1_rdata_nx;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_gnt0     <= 32'd0;
            perf_gnt1     <= 32'd0;
            perf_conflict <= 32'd0;
        end else begin
            if (grant && !gnt_idx)                  perf_gnt0     <= perf_gnt0 + 32'd1;
            if (grant && gnt_idx)                   perf_gnt1     <= perf_gnt1 + 32'd1;
            if ((state == IDLE) && m0_req && m1_req) perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin and a fixed-priority instance share all requester inputs.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_rw, m1_rw;

    logic        r_m0_done, r_m1_done, r_cpu_stall, r_mem_en;
    logic [31:0] r_m0_rdata, r_m1_rdata, r_mem_addr, r_mem_wdata, r_mem_rdata;
    logic [3:0]  r_mem_rw;
    logic        f_m0_done, f_m1_done, f_cpu_stall, f_mem_en;
    logic [31:0] f_m0_rdata, f_m1_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic [3:0]  f_mem_rw;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] r_perf_gnt0, r_perf_gnt1, r_perf_conflict;
    logic [31:0] f_perf_gnt0, f_perf_gnt1, f_perf_conflict;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0)) dut_rr (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw),
        .m0_done(r_m0_done), .m0_rdata(r_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw),
        .m1_done(r_m1_done), .m1_rdata(r_m1_rdata),
        .cpu_stall(r_cpu_stall), .mem_en(r_mem_en), .mem_addr(r_mem_addr),
        .mem_wdata(r_mem_wdata), .mem_rw(r_mem_rw), .mem_rdata(r_mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_gnt0(r_perf_gnt0), .perf_gnt1(r_perf_gnt1), .perf_conflict(r_perf_conflict)
`endif
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1)) dut_fx (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rw(m0_rw),
        .m0_done(f_m0_done), .m0_rdata(f_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rw(m1_rw),
        .m1_done(f_m1_done), .m1_rdata(f_m1_rdata),
        .cpu_stall(f_cpu_stall), .mem_en(f_mem_en), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rw(f_mem_rw), .mem_rdata(f_mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_gnt0(f_perf_gnt0), .perf_gnt1(f_perf_gnt1), .perf_conflict(f_perf_conflict)
`endif
    );

    // 16-word byte-writable memories with a registered read port, one per instance.
    logic [31:0] mem_r [16];
    logic [31:0] mem_f [16];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem_r[i] <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else if (r_mem_en) begin
            for (int b = 0; b < 4; b++)
                if (r_mem_rw[b]) mem_r[r_mem_addr[5:2]][8*b +: 8] <= r_mem_wdata[8*b +: 8];
            r_mem_rdata <= mem_r[r_mem_addr[5:2]];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem_f[i] <= 32'd0;
            f_mem_rdata <= 32'd0;
        end else if (f_mem_en) begin
            for (int b = 0; b < 4; b++)
                if (f_mem_rw[b]) mem_f[f_mem_addr[5:2]][8*b +: 8] <= f_mem_wdata[8*b +: 8];
            f_mem_rdata <= mem_f[f_mem_addr[5:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [31:0] obs_r, input logic [31:0] obs_f,
                        input logic [31:0] exp);
        chk({"rr ", tag}, obs_r, exp);
        chk({"fx ", tag}, obs_f, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int          n_r, n_f;
    logic [3:0]  ord_r, ord_f;

    initial begin
        reset = 1'b0;
        m0_req = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0; m0_rw = 4'd0;
        m1_req = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_rw = 4'd0;
        #3;
        chk2("rst mem_en",    32'(r_mem_en),    32'(f_mem_en),    32'd0);
        chk2("rst mem_rw",    32'(r_mem_rw),    32'(f_mem_rw),    32'd0);
        chk2("rst mem_addr",  r_mem_addr,       f_mem_addr,       32'd0);
        chk2("rst m0_done",   32'(r_m0_done),   32'(f_m0_done),   32'd0);
        chk2("rst m1_done",   32'(r_m1_done),   32'(f_m1_done),   32'd0);
        chk2("rst cpu_stall", 32'(r_cpu_stall), 32'(f_cpu_stall), 32'd0);
        cyc(); cyc();
        reset = 1'b1;
        cyc();

        // Full-word CPU write: 2-cycle stall, done right after the single memory cycle.
        m0_addr = 32'h10; m0_wdata = 32'hDEADBEEF; m0_rw = 4'b1111; m0_req = 1'b1;
        #1;
        chk2("wr req stall", 32'(r_cpu_stall), 32'(f_cpu_stall), 32'd1);
        chk2("wr req mem_en", 32'(r_mem_en), 32'(f_mem_en), 32'd0);
        cyc();
        chk2("wr acc mem_en", 32'(r_mem_en), 32'(f_mem_en), 32'd1);
        chk2("wr acc addr", r_mem_addr, f_mem_addr, 32'h10);
        chk2("wr acc wdata", r_mem_wdata, f_mem_wdata, 32'hDEADBEEF);
        chk2("wr acc rw", 32'(r_mem_rw), 32'(f_mem_rw), 32'hF);
        chk2("wr acc stall", 32'(r_cpu_stall), 32'(f_cpu_stall), 32'd1);
        cyc();
        chk2("wr done", 32'(r_m0_done), 32'(f_m0_done), 32'd1);
        chk2("wr done mem_en", 32'(r_mem_en), 32'(f_mem_en), 32'd0);
        chk2("wr done mem_rw", 32'(r_mem_rw), 32'(f_mem_rw), 32'd0);
        chk2("wr done stall", 32'(r_cpu_stall), 32'(f_cpu_stall), 32'd0);
        m0_req = 1'b0; m0_rw = 4'd0;
        cyc();
        chk2("wr done drop", 32'(r_m0_done), 32'(f_m0_done), 32'd0);

        // DMA read of the word just written: done and data 3 cycles after req.
        m1_addr = 32'h10; m1_rw = 4'd0; m1_req = 1'b1;
        cyc();
        chk2("rd acc mem_en", 32'(r_mem_en), 32'(f_mem_en), 32'd1);
        chk2("rd acc rw", 32'(r_mem_rw), 32'(f_mem_rw), 32'd0);
        chk2("rd acc done", 32'(r_m1_done), 32'(f_m1_done), 32'd0);
        cyc();
        chk2("rd wait mem_en", 32'(r_mem_en), 32'(f_mem_en), 32'd0);
        chk2("rd wait done", 32'(r_m1_done), 32'(f_m1_done), 32'd0);
        cyc();
        chk2("rd m1_done", 32'(r_m1_done), 32'(f_m1_done), 32'd1);
        chk2("rd m1_rdata", r_m1_rdata, f_m1_rdata, 32'hDEADBEEF);
        chk2("rd m0_done", 32'(r_m0_done), 32'(f_m0_done), 32'd0);
        m1_req = 1'b0;
        cyc();
        chk2("rd done drop", 32'(r_m1_done), 32'(f_m1_done), 32'd0);
        chk2("rd rdata hold", r_m1_rdata, f_m1_rdata, 32'hDEADBEEF);

        // Byte write; fields changed after the grant must not reach the memory.
        m0_addr = 32'h20; m0_wdata = 32'h0000AB00; m0_rw = 4'b0010; m0_req = 1'b1;
        #1;
        chk2("bw idle rw", 32'(r_mem_rw), 32'(f_mem_rw), 32'd0);
        cyc();
        chk2("bw acc rw", 32'(r_mem_rw), 32'(f_mem_rw), 32'h2);
        m0_addr = 32'hFFC; m0_wdata = 32'hFFFFFFFF;
        #1;
        chk2("bw latched addr", r_mem_addr, f_mem_addr, 32'h20);
        chk2("bw latched wdata", r_mem_wdata, f_mem_wdata, 32'h0000AB00);
        cyc();
        chk2("bw done rw", 32'(r_mem_rw), 32'(f_mem_rw), 32'd0);
        chk2("bw done", 32'(r_m0_done), 32'(f_m0_done), 32'd1);
        m0_req = 1'b0; m0_rw = 4'd0;
        cyc();
        chk2("bw after rw", 32'(r_mem_rw), 32'(f_mem_rw), 32'd0);
        m1_addr = 32'h20; m1_req = 1'b1;
        cyc(); cyc(); cyc();
        chk2("bw rdback done", 32'(r_m1_done), 32'(f_m1_done), 32'd1);
        chk2("bw rdback data", r_m1_rdata, f_m1_rdata, 32'h0000AB00);
        m1_req = 1'b0;
        cyc();

        // Both ports read continuously for 16 cycles: 4 accesses per instance.
        m0_addr = 32'h10; m0_rw = 4'd0; m1_addr = 32'h20; m1_rw = 4'd0;
        m0_req = 1'b1; m1_req = 1'b1;
`ifdef DMEM_ARB_PERF_EN
        chk2("perf conflict pre", r_perf_conflict, f_perf_conflict, 32'd0);
`endif
        n_r = 0; n_f = 0; ord_r = 4'd0; ord_f = 4'd0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("rr done exclusive", 32'(r_m0_done & r_m1_done), 32'd0);
            chk("fx done exclusive", 32'(f_m0_done & f_m1_done), 32'd0);
            if (r_m0_done) begin
                if (n_r < 4) ord_r[n_r] = 1'b0;
                n_r++;
                chk("rr conf m0_rdata", r_m0_rdata, 32'hDEADBEEF);
            end
            if (r_m1_done) begin
                if (n_r < 4) ord_r[n_r] = 1'b1;
                n_r++;
                chk("rr conf m1_rdata", r_m1_rdata, 32'h0000AB00);
            end
            if (f_m0_done) begin
                if (n_f < 4) ord_f[n_f] = 1'b0;
                n_f++;
                chk("fx conf m0_rdata", f_m0_rdata, 32'hDEADBEEF);
            end
            if (f_m1_done) begin
                if (n_f < 4) ord_f[n_f] = 1'b1;
                n_f++;
            end
        end
        chk("rr conf count", 32'(n_r), 32'd4);
        chk("rr conf order", 32'(ord_r), 32'b1010);
        chk("fx conf count", 32'(n_f), 32'd4);
        chk("fx conf order", 32'(ord_f), 32'b0000);
`ifdef DMEM_ARB_PERF_EN
        chk2("perf conflict", r_perf_conflict, f_perf_conflict, 32'd8);
        chk("rr perf gnt0", r_perf_gnt0, 32'd4);
        chk("rr perf gnt1", r_perf_gnt1, 32'd4);
        chk("fx perf gnt0", f_perf_gnt0, 32'd6);
        chk("fx perf gnt1", f_perf_gnt1, 32'd2);
`endif
        m0_req = 1'b0; m1_req = 1'b0;
        cyc(); cyc();

        // Reset in RDWAIT of a CPU read aborts it; port 0 then wins the first conflict.
        m0_addr = 32'h10; m0_rw = 4'd0; m0_req = 1'b1;
        cyc();
        chk2("abort acc mem_en", 32'(r_mem_en), 32'(f_mem_en), 32'd1);
        cyc();
        chk2("abort rdwait done", 32'(r_m0_done), 32'(f_m0_done), 32'd0);
        reset = 1'b0; m0_req = 1'b0;
        #1;
        chk2("abort mem_en", 32'(r_mem_en), 32'(f_mem_en), 32'd0);
        chk2("abort mem_rw", 32'(r_mem_rw), 32'(f_mem_rw), 32'd0);
        chk2("abort mem_addr", r_mem_addr, f_mem_addr, 32'd0);
        chk2("abort mem_wdata", r_mem_wdata, f_mem_wdata, 32'd0);
        chk2("abort m0_done", 32'(r_m0_done), 32'(f_m0_done), 32'd0);
        chk2("abort m0_rdata", r_m0_rdata, f_m0_rdata, 32'd0);
        chk2("abort m1_rdata", r_m1_rdata, f_m1_rdata, 32'd0);
        chk2("abort stall", 32'(r_cpu_stall), 32'(f_cpu_stall), 32'd0);
`ifdef DMEM_ARB_PERF_EN
        chk2("abort perf gnt0", r_perf_gnt0, f_perf_gnt0, 32'd0);
`endif
        cyc();
        chk2("abort in rst done", 32'(r_m0_done), 32'(f_m0_done), 32'd0);
        reset = 1'b1;
        cyc();
        chk2("abort post done", 32'(r_m0_done), 32'(f_m0_done), 32'd0);
        m0_addr = 32'h30; m0_wdata = 32'h11111111; m0_rw = 4'hF;
        m1_addr = 32'h34; m1_wdata = 32'h22222222; m1_rw = 4'hF;
        m0_req = 1'b1; m1_req = 1'b1;
        cyc();
        chk2("post rst gnt addr", r_mem_addr, f_mem_addr, 32'h30);
        chk2("post rst gnt wdata", r_mem_wdata, f_mem_wdata, 32'h11111111);
        cyc();
        chk2("post rst m0_done", 32'(r_m0_done), 32'(f_m0_done), 32'd1);
        chk2("post rst m1_done", 32'(r_m1_done), 32'(f_m1_done), 32'd0);
        m0_req = 1'b0; m1_req = 1'b0;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
